// File: rtl/pht_sat.sv
// Pattern history table: flop array of saturating counters with optional
// gshare hashing, registered lookup and same-cycle update bypass.
module pht_sat #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned HIST_WIDTH = 9,
  parameter int unsigned CTR_INIT   = 1,
  localparam int unsigned GW        = (HIST_WIDTH > 0) ? HIST_WIDTH : 1
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] in_lookup_pc,
  output logic                  out_pred_valid,
  output logic                  out_prediction,
  output logic [ADDR_WIDTH-1:0] out_pred_index,
  output logic [CTR_WIDTH-1:0]  out_pred_ctr,
  input  logic                  in_update_valid,
  input  logic [ADDR_WIDTH-1:0] in_update_index,
  input  logic                  in_update_taken,
  input  logic                  in_flush,
  output logic [GW-1:0]         out_ghr
);

  localparam int unsigned ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_RST  = CTR_WIDTH'(CTR_INIT);

  logic [CTR_WIDTH-1:0]  ctr_q [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_d;
  logic [ADDR_WIDTH-1:0] lookup_idx;
  logic [CTR_WIDTH-1:0]  rd_ctr;

  logic                  pred_valid_q;
  logic                  prediction_q;
  logic [ADDR_WIDTH-1:0] pred_index_q;
  logic [CTR_WIDTH-1:0]  pred_ctr_q;

  // Saturating next value for the entry being updated.
  always_comb begin
    ctr_d = ctr_q[in_update_index];
    if (in_update_taken) begin
      if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_WIDTH'(1);
    end else begin
      if (ctr_d != '0) ctr_d = ctr_d - CTR_WIDTH'(1);
    end
  end

  // Counter storage; each entry only changes when it is the update target.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
        ctr_q[i] <= CTR_RST;
      end else if (in_update_valid && (in_update_index == ADDR_WIDTH'(i))) begin
        ctr_q[i] <= ctr_d;
      end
    end
  end

  // Global history: shifts in resolved directions, cleared by flush.
  if (HIST_WIDTH > 0) begin : g_ghr
    logic [HIST_WIDTH-1:0] ghr_q;
    logic [HIST_WIDTH-1:0] ghr_d;

    // Next GHR: flush wins over a shift.
    always_comb begin
      ghr_d = ghr_q;
      if (in_flush) begin
        ghr_d = '0;
      end else if (in_update_valid) begin
        ghr_d = HIST_WIDTH'({ghr_q, in_update_taken});
      end
    end

    // GHR register.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) ghr_q <= '0;
      else           ghr_q <= ghr_d;
    end

    assign lookup_idx = in_lookup_pc ^ ADDR_WIDTH'(ghr_q);
    assign out_ghr    = ghr_q;
  end else begin : g_no_ghr
    assign lookup_idx = in_lookup_pc;
    assign out_ghr    = '0;
  end

  // Read port with bypass of a same-cycle update to the same entry.
  always_comb begin
    rd_ctr = ctr_q[lookup_idx];
    if (in_update_valid && (in_update_index == lookup_idx)) rd_ctr = ctr_d;
  end

  // Registered prediction; payload holds when no lookup is issued.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_index_q <= '0;
      pred_ctr_q   <= '0;
    end else begin
      pred_valid_q <= in_lookup_valid;
      if (in_lookup_valid) begin
        prediction_q <= rd_ctr[CTR_WIDTH-1];
        pred_index_q <= lookup_idx;
        pred_ctr_q   <= rd_ctr;
      end
    end
  end

  assign out_pred_valid = pred_valid_q;
  assign out_prediction = prediction_q;
  assign out_pred_index = pred_index_q;
  assign out_pred_ctr   = pred_ctr_q;

endmodule

// File: doc/pht_sat.md
Name: pht_sat

Overview:
- Parametrised pattern history table for the BPU: an array of N-bit saturating counters.
- Lookup and update are separate ports: lookup on the fetch side, update from branch resolution in execute.
- Optional gshare indexing: the lookup PC index is XORed with an internal global history register (GHR), which shifts on every resolved branch.
- Prediction is registered, one cycle after lookup; fetch pipelines its own PC alongside.

Parameters:
- ADDR_WIDTH, 9, table index width; entries = 2^ADDR_WIDTH.
- CTR_WIDTH, 2, counter width, legal range 1..4.
- HIST_WIDTH, 9, GHR width, legal range 0..ADDR_WIDTH; 0 = pure bimodal (no GHR, index = PC bits).
- CTR_INIT, 1, counter reset value, must be < 2^CTR_WIDTH.

Ports:
- in_Clk, input, 1, clock, rising edge.
- in_Rst_N, input, 1, asynchronous active-low reset.
- in_lookup_valid, input, 1, lookup request this cycle.
- in_lookup_pc, input, ADDR_WIDTH, PC index bits (caller slices PC[ADDR_WIDTH+1:2]).
- out_pred_valid, output, 1, registered: lookup issued previous cycle.
- out_prediction, output, 1, registered taken prediction (counter MSB).
- out_pred_index, output, ADDR_WIDTH, registered hashed index used; returned on update.
- out_pred_ctr, output, CTR_WIDTH, registered counter value read.
- in_update_valid, input, 1, resolved conditional branch this cycle.
- in_update_index, input, ADDR_WIDTH, index from the original out_pred_index.
- in_update_taken, input, 1, resolved direction.
- in_flush, input, 1, synchronous GHR clear (pipeline redirect/exception).
- out_ghr, output, max(HIST_WIDTH,1), current GHR; reads 0 when HIST_WIDTH=0.

Behaviour:
- Reset (async, in_Rst_N=0): all counters=CTR_INIT; GHR=0; out_pred_valid=0, out_prediction=0, out_pred_index=0, out_pred_ctr=0. Release is synchronous to in_Clk.
- Index: idx = in_lookup_pc XOR {zeros, GHR} (GHR in LSBs, zero-extended to ADDR_WIDTH). HIST_WIDTH=0: idx = in_lookup_pc.
- Lookup, 1-cycle latency: on a rising edge with in_lookup_valid=1:
  - out_pred_valid<=1, out_pred_index<=idx, out_pred_ctr<=ctr[idx], out_prediction<=ctr[idx][CTR_WIDTH-1].
  - With in_lookup_valid=0: out_pred_valid<=0; other outputs hold.
- Update: on a rising edge with in_update_valid=1, counter c=ctr[in_update_index]:
  - taken: c<=min(c+1, 2^CTR_WIDTH-1).
  - not taken: c<=max(c-1, 0).
  - Arithmetic is CTR_WIDTH-bit with explicit saturation; no wrap at either end.
  - No other entry is modified.
- GHR: on update_valid, GHR<={GHR[HIST_WIDTH-2:0], in_update_taken} (HIST_WIDTH=1: GHR<=taken). GHR is non-speculative.
- Flush: in_flush=1 sets GHR<=0 and has priority over a GHR shift the same cycle. The counter update in that cycle still occurs.
- Same-cycle lookup + update to the same idx (bypass): out_pred_ctr/out_prediction reflect the post-update (saturated) value.
- Same-cycle lookup + update, hash: lookup idx uses the pre-update GHR value.
- Different indices in the same cycle: both operations complete independently.
- Reset asserted mid-operation: counters, GHR and outputs are cleared immediately. An in-flight update is discarded.
- Storage: flop array (no SRAM macro) so reset clears every entry. Synthesis sizing is the caller's concern.

Test Plan:
- Reset, then lookup pc=0x005 (HIST_WIDTH=0, defaults) -> next cycle out_pred_valid=1, out_pred_ctr=1, out_prediction=0, out_pred_index=0x005.
- Three taken updates at idx 0x005, then one more taken -> ctr 2,3,3,3 (saturates at 3). Lookup -> prediction=1. Four not-taken updates -> 2,1,0,0; prediction=0.
- CTR_WIDTH=3, CTR_INIT=3: one taken update -> ctr=4, prediction=1. Eight not-taken updates -> ctr=0, no wrap to 7.
- HIST_WIDTH=4: updates taken,taken,not,taken -> out_ghr=4'b1101. Lookup pc=0x010 -> out_pred_index=0x01D. Same cycle update+flush -> GHR=0, counter still updated.
- Same-cycle lookup pc=0x020 and not-taken update idx 0x020 (ctr=2, HIST_WIDTH=0) -> out_pred_ctr=1, out_prediction=0.
- Assert in_Rst_N=0 asynchronously mid-stream after entries trained -> outputs immediately 0. After release, lookup of any trained index returns CTR_INIT.
